// File: rtl/bcd_timer_nd.sv
// bcd_timer_nd
//   N-digit BCD countdown / count-up timer core. It sits between the 1 s
//   timebase and the display/buzzer path, and provides run/pause/alarm
//   control, auto-reload and a one-cycle terminal beep.
//
// Parameters
//   DIGITS      number of BCD digits (bcd / load_val are 4*DIGITS bits)
//   ALARM_TICKS ticks spent in ALARM before returning to IDLE; 0 = wait for ack
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   tick        single-cycle count enable
//   clear       bcd <= 0, state -> IDLE (reload register kept)
//   load        load clamped load_val into bcd and reload register (not in RUN)
//   load_val    preset value, BCD
//   start       IDLE/PAUSE -> RUN if bcd is not already at terminal
//   stop        RUN -> PAUSE
//   mode_up     direction (1 = up to reload value, 0 = down to 0), latched on start
//   auto_reload 1 = wrap at terminal and keep running, 0 = enter ALARM
//   ack         leave ALARM
//   bcd         current count
//   zero        bcd == 0
//   running     state == RUN
//   alarm       state == ALARM
//   beep        one-cycle pulse on reaching terminal
//   state       IDLE=0, RUN=1, PAUSE=2, ALARM=3 (also serves as the FSM debug view)
//
// Control inputs are strictly prioritised by presence, not by acceptance:
// reset > clear > load > stop > start > tick > ack. A higher-priority input
// that is asserted masks every lower one in that cycle even when it is itself
// ignored in the current state (e.g. start+stop in PAUSE stays in PAUSE).

module bcd_timer_nd #(
  parameter int DIGITS      = 4,
  parameter int ALARM_TICKS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode_up,
  input  logic                  auto_reload,
  input  logic                  ack,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  zero,
  output logic                  running,
  output logic                  alarm,
  output logic                  beep,
  output logic [1:0]            state
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    bcd_q, bcd_d;
  logic [W-1:0]    reload_q, reload_d;
  logic            dir_up_q, dir_up_d;
  logic [CW-1:0]   acnt_q, acnt_d;
  logic            beep_q, beep_d;

  logic [W-1:0]    term_latched;
  logic [W-1:0]    term_start;
  logic [W-1:0]    step_val;
  logic [W-1:0]    load_clamped;

  // Any digit above 9 is forced to 9.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // BCD +1 with ripple carry; 9 -> 0 passes the carry on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD -1 with ripple borrow; 0 -> 9 passes the borrow on.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Terminal for counting uses the latched direction; the start check uses
  // the direction being requested with this start.
  assign term_latched = dir_up_q ? reload_q : '0;
  assign term_start   = mode_up  ? reload_q : '0;
  assign step_val     = dir_up_q ? bcd_inc(bcd_q) : bcd_dec(bcd_q);
  assign load_clamped = bcd_clamp(load_val);

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    reload_d = reload_q;
    dir_up_d = dir_up_q;
    acnt_d   = acnt_q;
    beep_d   = 1'b0;

    if (clear) begin
      bcd_d   = '0;
      state_d = IDLE;
    end else if (load) begin
      if (state_q != RUN) begin
        bcd_d    = load_clamped;
        reload_d = load_clamped;
        if (state_q == ALARM) state_d = IDLE;
      end
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      if ((state_q == IDLE || state_q == PAUSE) && (bcd_q != term_start)) begin
        state_d  = RUN;
        dir_up_d = mode_up;
      end
    end else if (tick) begin
      case (state_q)
        RUN: begin
          // Sitting on terminal while still in RUN only happens after an
          // auto-reload terminal event: this tick restarts instead of stepping.
          if (bcd_q == term_latched) begin
            bcd_d = dir_up_q ? '0 : reload_q;
          end else begin
            bcd_d = step_val;
            if (step_val == term_latched) begin
              beep_d = 1'b1;
              if (!auto_reload) begin
                state_d = ALARM;
                acnt_d  = '0;
              end
            end
          end
        end
        ALARM: begin
          if (ALARM_TICKS > 0) begin
            if (acnt_q == CW'(ALARM_TICKS - 1)) begin
              state_d = IDLE;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end else if (ack) begin
      if (state_q == ALARM) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      reload_q <= '0;
      dir_up_q <= 1'b0;
      acnt_q   <= '0;
      beep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      reload_q <= reload_d;
      dir_up_q <= dir_up_d;
      acnt_q   <= acnt_d;
      beep_q   <= beep_d;
    end
  end

  assign bcd     = bcd_q;
  assign zero    = (bcd_q == '0);
  assign running = (state_q == RUN);
  assign alarm   = (state_q == ALARM);
  assign beep    = beep_q;
  assign state   = state_q;

endmodule

// File: tb/tb_bcd_timer_nd.sv
// tb_bcd_timer_nd
//   Directed bench for bcd_timer_nd. A 4-digit and a 6-digit instance share
//   the clock. The driver pushes the expected post-edge response into exp_q,
//   tagged with the cycle it belongs to; the monitor samples on the falling
//   edge and pops/compares every entry due in that cycle.
//
// Handshake: inputs are driven 1 time unit after a rising edge and held for
// exactly one cycle; the response is valid on the following falling edge.

module tb_bcd_timer_nd;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_R = 2'd1;
  localparam logic [1:0] S_P = 2'd2;
  localparam logic [1:0] S_A = 2'd3;

  // Entry layout: {cyc[15:0], sel6, id[7:0], bcd[23:0], state[1:0], beep}
  localparam int EW = 52;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        reset, clear, load, start, stop, tick, ack, mode_up, auto_reload;
  logic [15:0] load_val;
  logic [15:0] bcd4;
  logic        zero4, running4, alarm4, beep4;
  logic [1:0]  state4;

  logic        reset6, load6, start6, tick6, lo;
  logic [23:0] load_val6;
  logic [23:0] bcd6;
  logic        zero6, running6, alarm6, beep6;
  logic [1:0]  state6;

  bcd_timer_nd #(.DIGITS(4), .ALARM_TICKS(10)) dut4 (
    .clk(clk), .reset(reset), .tick(tick), .clear(clear), .load(load),
    .load_val(load_val), .start(start), .stop(stop), .mode_up(mode_up),
    .auto_reload(auto_reload), .ack(ack), .bcd(bcd4), .zero(zero4),
    .running(running4), .alarm(alarm4), .beep(beep4), .state(state4)
  );

  bcd_timer_nd #(.DIGITS(6), .ALARM_TICKS(10)) dut6 (
    .clk(clk), .reset(reset6), .tick(tick6), .clear(lo), .load(load6),
    .load_val(load_val6), .start(start6), .stop(lo), .mode_up(lo),
    .auto_reload(lo), .ack(lo), .bcd(bcd6), .zero(zero6),
    .running(running6), .alarm(alarm6), .beep(beep6), .state(state6)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic [29:0]   act_v, exp_v;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    vec_id = 8'd0;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][51:36] <= cyc[15:0]) begin
      e = exp_q.pop_front();
      exp_v = {e[26:3], e[2:1], e[0], (e[26:3] == 24'd0),
               (e[2:1] == S_R), (e[2:1] == S_A)};
      if (e[35])
        act_v = {bcd6, state6, beep6, zero6, running6, alarm6};
      else
        act_v = {8'd0, bcd4, state4, beep4, zero4, running4, alarm4};
      n_cmp++;
      if (e[51:36] != cyc[15:0]) begin
        n_bad++;
        $display("FAIL vec%0d: check missed its cycle (due %0d, now %0d)",
                 e[34:27], e[51:36], cyc);
      end else if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL vec%0d dut%0d: got bcd=%h st=%0d beep=%b zero=%b run=%b alarm=%b, want bcd=%h st=%0d beep=%b zero=%b run=%b alarm=%b",
                 e[34:27], e[35] ? 6 : 4,
                 act_v[29:6], act_v[5:4], act_v[3], act_v[2], act_v[1], act_v[0],
                 exp_v[29:6], exp_v[5:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [23:0] eb, input logic [1:0] es,
                      input logic ebp, input logic s6);
    exp_q.push_back({cyc[15:0] + 16'd1, s6, vec_id, eb, es, ebp});
    vec_id = vec_id + 8'd1;
  endtask

  task automatic step(input logic [23:0] eb, input logic [1:0] es,
                      input logic ebp, input logic s6);
    push(eb, es, ebp, s6);
    @(posedge clk);
    #1;
    reset = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0;
    stop = 1'b0; tick = 1'b0; ack = 1'b0;
    reset6 = 1'b0; load6 = 1'b0; start6 = 1'b0; tick6 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    tick = 1'b0; ack = 1'b0; mode_up = 1'b0; auto_reload = 1'b0;
    load_val = 16'h0000;
    reset6 = 1'b1; load6 = 1'b0; start6 = 1'b0; tick6 = 1'b0; lo = 1'b0;
    load_val6 = 24'h000000;
    @(posedge clk);
    #1;

    // reset state of both instances
    reset = 1'b1; reset6 = 1'b1;
    push(24'h0, S_I, 1'b0, 1'b1);
    step(24'h0, S_I, 1'b0, 1'b0);

    // count down 3 -> 0, alarm, ack
    load = 1'b1; load_val = 16'h0003;  step(24'h0003, S_I, 1'b0, 1'b0);
    start = 1'b1;                      step(24'h0003, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0002, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0001, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0000, S_A, 1'b1, 1'b0);
                                       step(24'h0000, S_A, 1'b0, 1'b0);
    ack = 1'b1;                        step(24'h0000, S_I, 1'b0, 1'b0);

    // borrow across digits, pause, clamping
    load = 1'b1; load_val = 16'h0100;  step(24'h0100, S_I, 1'b0, 1'b0);
    start = 1'b1;                      step(24'h0100, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0099, S_R, 1'b0, 1'b0);
    stop = 1'b1;                       step(24'h0099, S_P, 1'b0, 1'b0);
    load = 1'b1; load_val = 16'h00A5;  step(24'h0095, S_P, 1'b0, 1'b0);
    clear = 1'b1;                      step(24'h0000, S_I, 1'b0, 1'b0);
    load = 1'b1; load_val = 16'h00A5;  step(24'h0095, S_I, 1'b0, 1'b0);
    load = 1'b1; load_val = 16'hFA3C;  step(24'h9939, S_I, 1'b0, 1'b0);
    clear = 1'b1;                      step(24'h0000, S_I, 1'b0, 1'b0);
    start = 1'b1;                      step(24'h0000, S_I, 1'b0, 1'b0);

    // count up to reload value, alarm times out after 10 ticks
    load = 1'b1; load_val = 16'h0002;  step(24'h0002, S_I, 1'b0, 1'b0);
    clear = 1'b1;                      step(24'h0000, S_I, 1'b0, 1'b0);
    mode_up = 1'b1; start = 1'b1;      step(24'h0000, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0001, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0002, S_A, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick = 1'b1;                     step(24'h0002, S_A, 1'b0, 1'b0);
    end
    tick = 1'b1;                       step(24'h0002, S_I, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0002, S_I, 1'b0, 1'b0);

    // load while in ALARM returns to IDLE
    mode_up = 1'b0;
    load = 1'b1; load_val = 16'h0003;  step(24'h0003, S_I, 1'b0, 1'b0);
    start = 1'b1;                      step(24'h0003, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0002, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0001, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0000, S_A, 1'b1, 1'b0);
    load = 1'b1; load_val = 16'h0007;  step(24'h0007, S_I, 1'b0, 1'b0);

    // auto-reload down then up
    auto_reload = 1'b1;
    load = 1'b1; load_val = 16'h0002;  step(24'h0002, S_I, 1'b0, 1'b0);
    start = 1'b1;                      step(24'h0002, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0001, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0000, S_R, 1'b1, 1'b0);
    tick = 1'b1;                       step(24'h0002, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0001, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0000, S_R, 1'b1, 1'b0);
    load = 1'b1; load_val = 16'h0005;  step(24'h0000, S_R, 1'b0, 1'b0);
    stop = 1'b1; start = 1'b1;         step(24'h0000, S_P, 1'b0, 1'b0);
    start = 1'b1;                      step(24'h0000, S_P, 1'b0, 1'b0);
    mode_up = 1'b1; start = 1'b1;      step(24'h0000, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0001, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0002, S_R, 1'b1, 1'b0);
    tick = 1'b1;                       step(24'h0000, S_R, 1'b0, 1'b0);

    // start+tick from IDLE, reset mid-run beats tick
    auto_reload = 1'b0;
    clear = 1'b1;                      step(24'h0000, S_I, 1'b0, 1'b0);
    mode_up = 1'b0;
    load = 1'b1; load_val = 16'h0003;  step(24'h0003, S_I, 1'b0, 1'b0);
    start = 1'b1; tick = 1'b1;         step(24'h0003, S_R, 1'b0, 1'b0);
    tick = 1'b1;                       step(24'h0002, S_R, 1'b0, 1'b0);
    reset = 1'b1; tick = 1'b1;         step(24'h0000, S_I, 1'b0, 1'b0);
    start = 1'b1;                      step(24'h0000, S_I, 1'b0, 1'b0);

    // 6-digit instance: borrow through five digits, reset mid-count
    load6 = 1'b1; load_val6 = 24'h100000; step(24'h100000, S_I, 1'b0, 1'b1);
    start6 = 1'b1;                        step(24'h100000, S_R, 1'b0, 1'b1);
    tick6 = 1'b1;                         step(24'h099999, S_R, 1'b0, 1'b1);
    tick6 = 1'b1;                         step(24'h099998, S_R, 1'b0, 1'b1);
    reset6 = 1'b1; tick6 = 1'b1;          step(24'h000000, S_I, 1'b0, 1'b1);

    // drain: anything still queued was never checked
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
